instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), SHALL be the bubble value on IF_ID_instruction.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_addr  output  32  word-aligned fetch address, stable while imem_req_valid=1.
REQ-008 imem_rsp_valid  input  1  response data valid; at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 id_stall  input  1  decode stage cannot accept a new instruction.
REQ-011 branch_taken  input  1  redirect/flush request.
REQ-012 branch_target  input  32  redirect address.
REQ-013 IF_ID_instruction  output  32  instruction presented to the decode controller.
REQ-014 IF_ID_pc  output  32  address of IF_ID_instruction.
REQ-015 IF_ID_npc  output  32  IF_ID_pc + 4.
REQ-016 IF_ID_valid  output  1  IF_ID_* holds a live instruction.

Function
REQ-017 FSM states SHALL be REQ, WAIT, KILL, HOLD; at most one request outstanding.
REQ-018 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_valid & imem_req_ready go to WAIT; otherwise stay with address held.
REQ-019 WAIT: imem_req_valid=0; on imem_rsp_valid, if IF_ID_valid=0 or id_stall=0 load IF_ID_instruction=imem_rsp_data, IF_ID_pc=pc, IF_ID_npc=pc+4, IF_ID_valid=1, pc<=pc+4, go to REQ.
REQ-020 WAIT with imem_rsp_valid=1, IF_ID_valid=1, id_stall=1: capture data into a one-entry hold buffer, pc<=pc+4, go to HOLD.
REQ-021 HOLD: imem_req_valid=0; when id_stall=0 transfer hold buffer to IF_ID_* (valid=1), go to REQ.
REQ-022 When id_stall=1 and IF_ID_valid=1, IF_ID_* SHALL hold unchanged.
REQ-023 When id_stall=0 and no new instruction is loaded that cycle, IF_ID_valid SHALL clear to 0 and IF_ID_instruction SHALL become NOP_INSTR.
REQ-024 branch_taken=1 SHALL override id_stall and any response: next edge pc<=branch_target with bits [1:0] forced to 0, IF_ID_valid=0, IF_ID_instruction=NOP_INSTR, hold buffer discarded.
REQ-025 branch_taken in REQ (whether or not accepted that cycle) or HOLD: next state REQ at new pc; an accepted-same-cycle request goes to KILL instead.
REQ-026 branch_taken in WAIT without imem_rsp_valid: go to KILL; with imem_rsp_valid same cycle: response dropped, go to REQ.
REQ-027 KILL: imem_req_valid=0; next imem_rsp_valid discarded, then go to REQ; a further branch_taken in KILL only updates pc.
REQ-028 pc arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFC + 4 wraps to 32'h00000000.
REQ-029 Best-case throughput with 1-cycle memory: one instruction per 2 cycles.

Reset
REQ-030 While rst_n=0 at a rising edge: state=REQ, pc=RESET_PC, IF_ID_valid=0, IF_ID_instruction=NOP_INSTR, IF_ID_pc=0, IF_ID_npc=0, hold buffer empty, kill pending cleared.
REQ-031 imem_req_valid SHALL be 0 while rst_n=0 and assert in the first cycle after release with imem_addr=RESET_PC.
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request; a response arriving after reset release in REQ state is ignored.

Verification
REQ-033 Reset release, ready=1, 1-cycle memory returning 32'h00500093 at 0 -> IF_ID_instruction=32'h00500093, IF_ID_pc=0, IF_ID_npc=4, IF_ID_valid=1; next request addr=4.
REQ-034 imem_req_ready=0 for 3 cycles -> imem_addr held at 32'h00000004, no state change.
REQ-035 IF_ID_valid=1, id_stall=1, response 32'h40208133 arrives -> IF_ID_* unchanged, enters HOLD; id_stall=0 -> IF_ID_instruction=32'h40208133.
REQ-036 branch_taken=1, branch_target=32'h00000102 during WAIT -> IF_ID_valid=0, IF_ID_instruction=32'h00000013, late response discarded, next imem_addr=32'h00000100.
REQ-037 branch_taken and imem_rsp_valid in same cycle with id_stall=1 -> response dropped, flush applied, next imem_addr=branch_target&~3.
REQ-038 RESET_PC=32'hFFFFFFFC, one fetch -> IF_ID_npc=0, next imem_addr=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch stage feeding the IF/ID register
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        id_stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] IF_ID_instruction,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_npc,
   output logic        IF_ID_valid
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL, S_HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_data;
   logic [31:0] hold_pc;
   logic        req_accept;
   logic        if_id_free;

   // Request is a pure decode of the REQ state, gated so nothing is issued during reset.
   assign imem_req_valid = rst_n && (state == S_REQ);
   assign imem_addr      = pc;
   assign req_accept     = imem_req_valid && imem_req_ready;
   assign if_id_free     = !IF_ID_valid || !id_stall;

   // Fetch FSM, pc, hold buffer and IF/ID register; a branch overrides stalls and responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= S_REQ;
         pc                <= RESET_PC;
         hold_data         <= 32'h0;
         hold_pc           <= 32'h0;
         IF_ID_valid       <= 1'b0;
         IF_ID_instruction <= NOP_INSTR;
         IF_ID_pc          <= 32'h0;
         IF_ID_npc         <= 32'h0;
      end else if (branch_taken) begin
         pc                <= branch_target & ~32'h3;
         IF_ID_valid       <= 1'b0;
         IF_ID_instruction <= NOP_INSTR;
         case (state)
            S_REQ:   state <= req_accept ? S_KILL : S_REQ;
            S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_KILL;
            S_KILL:  state <= imem_rsp_valid ? S_REQ : S_KILL;
            S_HOLD:  state <= S_REQ;
            default: state <= S_REQ;
         endcase
      end else begin
         // Decode drained the current entry; a load below overrides this bubble.
         if (!id_stall) begin
            IF_ID_valid       <= 1'b0;
            IF_ID_instruction <= NOP_INSTR;
         end
         case (state)
            S_REQ: begin
               if (req_accept) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  pc <= pc + 32'd4;
                  if (if_id_free) begin
                     IF_ID_instruction <= imem_rsp_data;
                     IF_ID_pc          <= pc;
                     IF_ID_npc         <= pc + 32'd4;
                     IF_ID_valid       <= 1'b1;
                     state             <= S_REQ;
                  end else begin
                     hold_data <= imem_rsp_data;
                     hold_pc   <= pc;
                     state     <= S_HOLD;
                  end
               end
            end
            S_KILL: begin
               if (imem_rsp_valid) state <= S_REQ;
            end
            S_HOLD: begin
               if (!id_stall) begin
                  IF_ID_instruction <= hold_data;
                  IF_ID_pc          <= hold_pc;
                  IF_ID_npc         <= hold_pc + 32'd4;
                  IF_ID_valid       <= 1'b1;
                  state             <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] IF_ID_instruction;
   logic [31:0] IF_ID_pc;
   logic [31:0] IF_ID_npc;
   logic        IF_ID_valid;

   logic        w_rst_n;
   logic        w_req_valid;
   logic        w_req_ready;
   logic [31:0] w_addr;
   logic        w_rsp_valid;
   logic [31:0] w_rsp_data;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [31:0] w_npc;
   logic        w_valid;

   int checks   = 0;
   int failures = 0;

   instruction_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .id_stall(id_stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .IF_ID_instruction(IF_ID_instruction), .IF_ID_pc(IF_ID_pc), .IF_ID_npc(IF_ID_npc),
      .IF_ID_valid(IF_ID_valid)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
      .clk(clk), .rst_n(w_rst_n),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .id_stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
      .IF_ID_instruction(w_instr), .IF_ID_pc(w_pc), .IF_ID_npc(w_npc),
      .IF_ID_valid(w_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] data;
      logic        st;
      logic        br;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [31:0] e_npc;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];

   localparam logic [31:0] NOP = 32'h00000013;

   task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] data,
                      input logic st, input logic br, input logic [31:0] tgt,
                      input logic e_req, input logic [31:0] e_addr, input logic e_v,
                      input logic [31:0] e_instr, input logic [31:0] e_pc, input logic [31:0] e_npc);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.data = data; v.st = st; v.br = br; v.tgt = tgt;
      v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
      v.e_instr = e_instr; v.e_pc = e_pc; v.e_npc = e_npc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0BADF00D;
   endfunction

   initial begin
      logic        pend;
      logic [31:0] pend_data;
      sb_t         e;

      rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      id_stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      w_rst_n = 1'b0; w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;

      //  rst rdy rv data          st br tgt            req addr          v  instr          pc            npc
      add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h0);
      add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,        32'h0);
      add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h0);
      add(1, 0, 1, 32'h00500093, 0, 0, 32'h0,        1, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);
      add(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);
      add(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);
      add(1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);
      add(1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);
      add(1, 0, 1, 32'h40208133, 1, 0, 32'h0,        0, 32'h8,        1, 32'h00500093, 32'h0,        32'h4);
      add(1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h8,        1, 32'h00500093, 32'h0,        32'h4);
      add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        1, 32'h40208133, 32'h4,        32'h8);
      add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,        0, NOP,          32'h4,        32'h8);
      add(1, 0, 0, 32'h0,        0, 1, 32'h102,      0, 32'h100,      0, NOP,          32'h4,        32'h8);
      add(1, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        1, 32'h100,      0, NOP,          32'h4,        32'h8);
      add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100,      0, NOP,          32'h4,        32'h8);
      add(1, 0, 1, 32'h00A00113, 0, 0, 32'h0,        1, 32'h104,      1, 32'h00A00113, 32'h100,      32'h104);
      add(1, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h104,      1, 32'h00A00113, 32'h100,      32'h104);
      add(1, 0, 1, 32'h11111111, 1, 1, 32'h207,      1, 32'h204,      0, NOP,          32'h100,      32'h104);
      add(1, 1, 0, 32'h0,        0, 1, 32'h300,      0, 32'h300,      0, NOP,          32'h100,      32'h104);
      add(1, 0, 0, 32'h0,        0, 1, 32'h401,      0, 32'h400,      0, NOP,          32'h100,      32'h104);
      add(1, 0, 1, 32'h22222222, 0, 0, 32'h0,        1, 32'h400,      0, NOP,          32'h100,      32'h104);
      add(1, 0, 0, 32'h0,        0, 1, 32'h500,      1, 32'h500,      0, NOP,          32'h100,      32'h104);
      add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h500,      0, NOP,          32'h100,      32'h104);
      add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h0);
      add(1, 0, 1, 32'h33333333, 0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,        32'h0);
      add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h0);
      add(1, 0, 1, 32'h44444444, 1, 0, 32'h0,        1, 32'h4,        1, 32'h44444444, 32'h0,        32'h4);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst; imem_req_ready = vecs[i].rdy; imem_rsp_valid = vecs[i].rv;
         imem_rsp_data = vecs[i].data; id_stall = vecs[i].st;
         branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({imem_req_valid, imem_addr, IF_ID_valid, IF_ID_instruction, IF_ID_pc, IF_ID_npc} !==
             {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_npc}) begin
            failures++;
            $display("FAIL vec[%0d] got req=%0b addr=%h v=%0b instr=%h pc=%h npc=%h want req=%0b addr=%h v=%0b instr=%h pc=%h npc=%h",
                     i, imem_req_valid, imem_addr, IF_ID_valid, IF_ID_instruction, IF_ID_pc, IF_ID_npc,
                     vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_npc);
         end
      end

      // Wrap-around fetch at the top of the address space.
      w_rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("wrap_rst_req", {31'h0, w_req_valid}, 32'h0);
      w_rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("wrap_first_addr", w_addr, 32'hFFFFFFFC);
      chk("wrap_first_req", {31'h0, w_req_valid}, 32'h1);
      w_req_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      w_req_ready = 1'b0; w_rsp_valid = 1'b1; w_rsp_data = 32'h12345678;
      @(posedge clk); @(negedge clk);
      w_rsp_valid = 1'b0;
      chk("wrap_instr", w_instr, 32'h12345678);
      chk("wrap_pc", w_pc, 32'hFFFFFFFC);
      chk("wrap_npc", w_npc, 32'h0);
      chk("wrap_next_addr", w_addr, 32'h0);

      // Random ready/stall stream against a 1-cycle memory, scoreboard of issued fetches.
      branch_taken = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; id_stall = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      pend = 1'b0; pend_data = 32'h0;
      for (int c = 0; c < 420; c++) begin
         @(posedge clk); #1;
         imem_rsp_valid = pend; imem_rsp_data = pend_data; pend = 1'b0;
         if (c < 400) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_stall       = ($urandom_range(0, 2) == 0);
         end else begin
            imem_req_ready = 1'b0;
            id_stall       = 1'b0;
         end
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_data = mem_word(imem_addr);
            e.pc      = imem_addr;
            e.instr   = pend_data;
            sb_q.push_back(e);
         end
         if (IF_ID_valid && !id_stall) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_instr", IF_ID_pc, 32'hFFFFFFFF);
            end else begin
               e = sb_q.pop_front();
               chk("sb_instr", IF_ID_instruction, e.instr);
               chk("sb_pc", IF_ID_pc, e.pc);
               chk("sb_npc", IF_ID_npc, e.pc + 32'd4);
            end
         end
      end
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
